// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolver.
//   resolver_state_t : FSM encoding (IDLE, ADD, DONE)
//   DEFAULT_WIDTH    : default operand/result width
//   DEFAULT_CHUNK    : default bits resolved per cycle
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } resolver_state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

endpackage

// File: rtl/csa_resolver_chunk_adder.sv
// Combinational CHUNK-bit adder with carry in/out.
// Ports:
//   a, b  : CHUNK-bit addends
//   cin   : carry in
//   s     : CHUNK-bit sum
//   cout  : carry out of the top bit
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s      = w_full[CHUNK-1:0];
    assign cout   = w_full[CHUNK];

endmodule

// File: rtl/csa_resolver.sv
// Chunk-serial carry-propagate adder resolving a carry-save pair
// (in_sum, in_carry) into a binary result, CHUNK bits per cycle.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   in_sum, in_carry     : WIDTH-bit carry-save operand pair
//   out_valid / out_ready: result handshake (valid only in DONE)
//   out_result           : (in_sum + in_carry) mod 2^WIDTH
//   out_cout             : carry out of bit WIDTH-1
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("csa_resolver: WIDTH must be a multiple of CHUNK");
    end

    resolver_state_t r_state;
    resolver_state_t w_next;

    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic [IDXW-1:0]  r_idx;
    logic             r_cy;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;

    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_s;
    logic             w_cout;
    logic             w_last;

    assign w_a    = r_sum[int'(r_idx) * CHUNK +: CHUNK];
    assign w_b    = r_carry[int'(r_idx) * CHUNK +: CHUNK];
    assign w_last = (r_idx == LAST_IDX);

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (w_a),
        .b    (w_b),
        .cin  (r_cy),
        .s    (w_s),
        .cout (w_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = ADD;
            ADD:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    // Datapath: operand capture and chunk-by-chunk result write.
    // out_result is deliberately not cleared between transactions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum    <= '0;
            r_carry  <= '0;
            r_idx    <= '0;
            r_cy     <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sum   <= in_sum;
                        r_carry <= in_carry;
                        r_cy    <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                ADD: begin
                    r_result[int'(r_idx) * CHUNK +: CHUNK] <= w_s;
                    r_cy <= w_cout;
                    if (w_last) begin
                        r_cout <= w_cout;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are pure state decodes: no input-to-output path.
    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign out_result = r_result;
    assign out_cout   = r_cout;

endmodule
